// File: rtl/selector_1_to_2_stream_pkg.sv
// selector_pkg: shared FSM state encoding and port identifiers for selector_1_to_2_stream
package selector_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROUTE_A = 2'd1,
    ROUTE_B = 2'd2
  } state_t;
  localparam logic PORT_A = 1'b1;
  localparam logic PORT_B = 1'b0;
endpackage

// File: rtl/stream_reg_slice.sv
// stream_reg_slice: one-entry data+last valid/ready register stage with slot_free
module stream_reg_slice #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             wlast,
  output logic [WIDTH-1:0] data,
  output logic             last,
  output logic             valid,
  input  logic             ready,
  output logic             slot_free
);
  assign slot_free = !valid || ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      data  <= '0;
      last  <= 1'b0;
      valid <= 1'b0;
    end else if (wr) begin
      data  <= wdata;
      last  <= wlast;
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/selector_1_to_2_stream.sv
// selector_1_to_2_stream: registered 1-to-2 packet distributor, round-robin steering when SELECTOR_1_TO_2_RR_EN is defined
module selector_1_to_2_stream
  import selector_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic             in_sel,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  output logic             a_last,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  output logic             b_last,
  input  logic             b_ready,
  output logic             busy
);
  state_t state, state_nxt;
  logic idle_sel, target, accept, a_free, b_free;
`ifdef SELECTOR_1_TO_2_RR_EN
  logic rr_next;
  always_ff @(posedge clk) begin
    rr_next <= rst ? PORT_A : (accept && in_last) ? !rr_next : rr_next;
  end
  assign idle_sel = rr_next;
`else
  assign idle_sel = in_sel;
`endif
  always_comb begin
    target    = (state == IDLE) ? idle_sel : (state == ROUTE_A) ? PORT_A : PORT_B;
    in_ready  = (target == PORT_A) ? a_free : b_free;
    accept    = in_valid && in_ready;
    state_nxt = !accept ? state : in_last ? IDLE : (target == PORT_A) ? ROUTE_A : ROUTE_B;
  end
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : state_nxt;
  end
  assign busy = (state != IDLE);
  stream_reg_slice #(.WIDTH(WIDTH)) u_a (
    .clk(clk), .rst(rst), .wr(accept && target == PORT_A), .wdata(in_data), .wlast(in_last),
    .data(a_data), .last(a_last), .valid(a_valid), .ready(a_ready), .slot_free(a_free)
  );
  stream_reg_slice #(.WIDTH(WIDTH)) u_b (
    .clk(clk), .rst(rst), .wr(accept && target == PORT_B), .wdata(in_data), .wlast(in_last),
    .data(b_data), .last(b_last), .valid(b_valid), .ready(b_ready), .slot_free(b_free)
  );
endmodule

// File: tb/tb_selector_1_to_2_stream.sv
// tb_selector_1_to_2_stream: directed vector table plus randomized run against a packet-level reference model
module tb_selector_1_to_2_stream;
  logic clk = 1'b0;
  logic rst, in_valid, in_last, in_sel, in_ready;
  logic a_valid, a_last, a_ready, b_valid, b_last, b_ready, busy;
  logic [31:0] in_data, a_data, b_data;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  selector_1_to_2_stream #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_sel(in_sel), .in_ready(in_ready), .a_data(a_data), .a_valid(a_valid),
    .a_last(a_last), .a_ready(a_ready), .b_data(b_data), .b_valid(b_valid),
    .b_last(b_last), .b_ready(b_ready), .busy(busy)
  );
  typedef struct {
    logic r, v, s, l;
    logic [31:0] d;
    logic ar, br, ir, av;
    logic [31:0] ad;
    logic al, bv;
    logic [31:0] bd;
    logic bl, bz;
  } vec_t;
  vec_t vq[$];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, act, exp);
    end
  endtask
  task automatic drive(input logic r, v, s, l, input logic [31:0] d, input logic ar, br);
    rst = r; in_valid = v; in_sel = s; in_last = l; in_data = d; a_ready = ar; b_ready = br;
  endtask
  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 1, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask
  int lock;
  logic m_av, m_bv, m_al, m_bl, rr_m, tgt, eir, acc, hold;
  logic [31:0] m_ad, m_bd;
  initial begin
    drive(1, 0, 0, 0, 0, 1, 1);
    do_reset();
    chk("reset_a_valid", {31'b0, a_valid}, 0);
    chk("reset_b_valid", {31'b0, b_valid}, 0);
    chk("reset_a_data", a_data, 0);
    chk("reset_b_data", b_data, 0);
    chk("reset_busy", {31'b0, busy}, 0);
    chk("reset_in_ready", {31'b0, in_ready}, 1);
`ifndef SELECTOR_1_TO_2_RR_EN
    vq.push_back('{0,1,1,1,'h11,1,1, 1,1,'h11,1,0,0,0,0});
    vq.push_back('{0,1,0,1,'h22,1,1, 1,0,'h11,1,1,'h22,1,0});
    vq.push_back('{0,1,1,0,'hA0,1,1, 1,1,'hA0,0,0,'h22,1,1});
    vq.push_back('{0,1,0,0,'hA1,1,1, 1,1,'hA1,0,0,'h22,1,1});
    vq.push_back('{0,1,1,0,'hA2,1,1, 1,1,'hA2,0,0,'h22,1,1});
    vq.push_back('{0,1,0,1,'hA3,1,1, 1,1,'hA3,1,0,'h22,1,0});
    vq.push_back('{0,0,0,0,0,1,1, 1,0,'hA3,1,0,'h22,1,0});
    vq.push_back('{0,1,0,0,'hB0,1,1, 1,0,'hA3,1,1,'hB0,0,1});
    for (int i = 0; i < 3; i++) vq.push_back('{0,1,0,1,'hB1,1,0, 0,0,'hA3,1,1,'hB0,0,1});
    vq.push_back('{0,1,0,1,'hB1,1,1, 1,0,'hA3,1,1,'hB1,1,0});
    vq.push_back('{0,0,0,0,0,1,1, 1,0,'hA3,1,0,'hB1,1,0});
    vq.push_back('{0,1,1,1,'hC0,0,1, 1,1,'hC0,1,0,'hB1,1,0});
    vq.push_back('{0,1,0,0,'hD0,0,1, 1,1,'hC0,1,1,'hD0,0,1});
    vq.push_back('{0,1,0,0,'hD1,0,1, 1,1,'hC0,1,1,'hD1,0,1});
    vq.push_back('{0,1,0,1,'hD2,0,1, 1,1,'hC0,1,1,'hD2,1,0});
    vq.push_back('{0,1,1,1,'hE0,0,1, 0,1,'hC0,1,0,'hD2,1,0});
    vq.push_back('{0,1,1,1,'hE0,1,1, 1,1,'hE0,1,0,'hD2,1,0});
    vq.push_back('{0,0,0,0,0,1,1, 1,0,'hE0,1,0,'hD2,1,0});
    vq.push_back('{0,1,1,0,'hF0,1,1, 1,1,'hF0,0,0,'hD2,1,1});
    vq.push_back('{0,1,1,0,'hF1,1,1, 1,1,'hF1,0,0,'hD2,1,1});
    vq.push_back('{1,0,0,0,0,1,1, 1,0,0,0,0,0,0,0});
    vq.push_back('{0,1,0,1,'h99,1,1, 1,0,0,0,1,'h99,1,0});
    vq.push_back('{0,0,0,0,0,1,1, 1,0,0,0,0,'h99,1,0});
    foreach (vq[i]) begin
      drive(vq[i].r, vq[i].v, vq[i].s, vq[i].l, vq[i].d, vq[i].ar, vq[i].br);
      @(negedge clk);
      chk($sformatf("v%0d_in_ready", i), {31'b0, in_ready}, {31'b0, vq[i].ir});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_a_valid", i), {31'b0, a_valid}, {31'b0, vq[i].av});
      chk($sformatf("v%0d_a_data", i), a_data, vq[i].ad);
      chk($sformatf("v%0d_a_last", i), {31'b0, a_last}, {31'b0, vq[i].al});
      chk($sformatf("v%0d_b_valid", i), {31'b0, b_valid}, {31'b0, vq[i].bv});
      chk($sformatf("v%0d_b_data", i), b_data, vq[i].bd);
      chk($sformatf("v%0d_b_last", i), {31'b0, b_last}, {31'b0, vq[i].bl});
      chk($sformatf("v%0d_busy", i), {31'b0, busy}, {31'b0, vq[i].bz});
    end
`else
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 1, 32'h50 + i, 1, 1);
      @(posedge clk);
      #1;
      chk($sformatf("rr%0d_a_valid", i), {31'b0, a_valid}, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("rr%0d_b_valid", i), {31'b0, b_valid}, (i % 2 == 1) ? 1 : 0);
    end
`endif
    do_reset();
    lock = -1; rr_m = 1'b1; hold = 1'b0;
    m_av = 0; m_bv = 0; m_al = 0; m_bl = 0; m_ad = 0; m_bd = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!hold) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_sel = 1'($urandom_range(0, 1));
        in_last = ($urandom_range(0, 3) == 0);
        in_data = $urandom;
      end
      a_ready = ($urandom_range(0, 3) != 0);
      b_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
`ifdef SELECTOR_1_TO_2_RR_EN
      tgt = (lock < 0) ? rr_m : lock[0];
`else
      tgt = (lock < 0) ? in_sel : lock[0];
`endif
      eir = tgt ? (!m_av || a_ready) : (!m_bv || b_ready);
      chk($sformatf("rnd%0d_in_ready", c), {31'b0, in_ready}, {31'b0, eir});
      acc = in_valid && eir;
      @(posedge clk);
      #1;
      if (acc && tgt) begin
        m_av = 1; m_ad = in_data; m_al = in_last;
      end else if (m_av && a_ready) m_av = 0;
      if (acc && !tgt) begin
        m_bv = 1; m_bd = in_data; m_bl = in_last;
      end else if (m_bv && b_ready) m_bv = 0;
      if (acc) lock = in_last ? -1 : int'(tgt);
      if (acc && in_last) rr_m = !rr_m;
      hold = in_valid && !acc;
      chk($sformatf("rnd%0d_a_valid", c), {31'b0, a_valid}, {31'b0, m_av});
      chk($sformatf("rnd%0d_b_valid", c), {31'b0, b_valid}, {31'b0, m_bv});
      chk($sformatf("rnd%0d_a_data", c), a_data, m_ad);
      chk($sformatf("rnd%0d_b_data", c), b_data, m_bd);
      chk($sformatf("rnd%0d_a_last", c), {31'b0, a_last}, {31'b0, m_al});
      chk($sformatf("rnd%0d_b_last", c), {31'b0, b_last}, {31'b0, m_bl});
      chk($sformatf("rnd%0d_busy", c), {31'b0, busy}, (lock >= 0) ? 1 : 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/selector_1_to_2_stream.md
Name: selector_1_to_2_stream

Overview:
- Registered 1-to-2 stream distributor: the opposite direction of the 2-to-1 selector.
- Accepts one valid/ready word stream and steers whole packets to output port A or port B.
- Sits in the lab 4/5 datapath between a single producer and two consumer datapaths.
- Steering choice is locked per packet by a small FSM. Each output has a one-entry register stage.

Parameters:
- WIDTH, 32, data word width in bits.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  input word.
- in_valid  input  1  input word present.
- in_last  input  1  word is the final word of its packet.
- in_sel  input  1  port choice, sampled on a packet's first beat only; 1 = port A, 0 = port B.
- in_ready  output  1  block accepts the word this cycle.
- a_data  output  WIDTH  port A word.
- a_valid  output  1  port A word present.
- a_last  output  1  port A end of packet.
- a_ready  input  1  port A consumer accepts.
- b_data  output  WIDTH  port B word.
- b_valid  output  1  port B word present.
- b_last  output  1  port B end of packet.
- b_ready  input  1  port B consumer accepts.
- busy  output  1  packet in progress (FSM not IDLE).

Behaviour:
- Clock and reset:
  - Single clock domain.
  - rst is synchronous and active-high. All state clears on the clk edge where rst=1.
- Reset values:
  - state=IDLE.
  - a_valid=0, b_valid=0, a_last=0, b_last=0.
  - a_data=0, b_data=0.
  - busy=0.
  - in_ready reflects the reset state.
- A transfer happens on any side when valid and ready are both 1 at a clk edge.
- FSM states: IDLE, ROUTE_A, ROUTE_B.
  - Target port: in IDLE, target = in_sel ? A : B. In ROUTE_A / ROUTE_B, target is the locked port; in_sel is ignored.
  - in_ready = slot_free(target), where slot_free(X) = !X_valid || X_ready. The ready path is combinational; the data path is registered.
  - IDLE + accept + in_last=1 -> stay IDLE (single-beat packet).
  - IDLE + accept + in_last=0 -> ROUTE_A or ROUTE_B, per target.
  - ROUTE_X + accept + in_last=1 -> IDLE.
  - No accept -> state holds.
- Output stage X:
  - On accept to X: X_data <= in_data, X_last <= in_last, X_valid <= 1.
  - Else if X_valid && X_ready: X_valid <= 0.
  - X_data and X_last hold while X_valid=1 and X_ready=0.
- Latency and throughput:
  - Latency is 1 cycle from input accept to X_valid.
  - Full throughput: 1 word/cycle when the consumer holds ready=1.
- Non-target port: never written. Any word it already holds drains independently.
- Backpressure: target slot full and consumer not ready -> in_ready=0. The producer must hold in_data, in_last and in_sel stable.
- busy = (state != IDLE).
- Reset mid-packet: packet is abandoned, both output words are dropped, FSM returns to IDLE.
- in_valid=0 in IDLE: no state change, no output written.

Optional Feature:
- Macro: SELECTOR_1_TO_2_RR_EN.
- Defined:
  - in_sel is ignored.
  - A 1-bit register rr_next (reset 1 = A) chooses the IDLE target.
  - rr_next toggles on each accepted beat with in_last=1, so packets alternate A, B, A, ...
- Undefined: steering comes from in_sel as above and the rr_next register is absent.

Decomposition:
- Package selector_pkg:
  - state enum: IDLE=2'd0, ROUTE_A=2'd1, ROUTE_B=2'd2.
  - localparam PORT_A=1'b1, PORT_B=1'b0.
- One sub-module, stream_reg_slice:
  - One-entry WIDTH+1 (data+last) valid/ready register with slot_free output.
  - Instantiated twice, for A and B.
- FSM and steering stay in the top module.

Test Plan:
- Reset mid-packet: rst=1 after 2 beats of a 4-beat packet to A -> next cycle a_valid=0, busy=0, state IDLE. The next packet with in_sel=0 goes to B.
- Single-beat packets, all ready=1:
  - in_sel=1, data 0x11, last=1 -> a_data=0x11, a_last=1, a_valid=1 one cycle later; b_valid stays 0.
  - Next cycle in_sel=0, data 0x22 -> b_data=0x22.
- 4-beat packet 0xA0..0xA3 with in_sel=1 on beat 0 and in_sel toggled on beats 1-3 -> all four words on A in order, busy=1 until beat 3 is accepted.
- Backpressure: packet to B with b_ready=0 for 3 cycles -> in_ready=0 after the first beat, b_data held at the first word, no loss or duplication once b_ready=1.
- Independent drain: a_valid=1 held with a_ready=0, then a packet to B with b_ready=1 -> B streams at 1 word/cycle while the A word stays held.
- With SELECTOR_1_TO_2_RR_EN: 4 single-beat packets with in_sel=0 -> ports A, B, A, B.
